// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_pkg
//  Description : Shared definitions for the ALU16 wide-arithmetic datapath:
//                slice width, sequencer state encoding and the legality
//                check for the number of 16-bit words per operand.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Width of the single carry-lookahead slice reused across all words.
    localparam int SLICE_W = 16;

    // Sequencer state encoding (kept as plain 2-bit constants so that
    // older tools and netlist scripts see fixed codes).
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Legal operand widths are 2..16 words of SLICE_W bits.
    function automatic bit words_legal(input int words);
        return (words >= 2) && (words <= 16);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/add16_slice.sv
`default_nettype none
// ============================================================================
//  Module      : add16_slice
//  Description : 16-bit two-level carry-lookahead adder. Four 4-bit groups
//                produce group generate/propagate; a second-level unit
//                derives every group carry-in directly from cin, so no
//                group waits on a rippled carry.
//  Ports       : a, b     - 16-bit addends
//                cin      - carry into bit 0
//                sum      - 16-bit sum
//                cout     - carry out of bit 15
//                msb_cin  - carry into bit 15 (cout ^ msb_cin = signed ovf)
//  Revision    : 1.0 - initial release
// ============================================================================
module add16_slice
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               msb_cin
);

    localparam int GROUPS = SLICE_W / 4;

    logic [SLICE_W-1:0] w_p;    // bit propagate
    logic [SLICE_W-1:0] w_g;    // bit generate
    logic [SLICE_W-1:0] w_bc;   // carry into each bit
    logic [GROUPS-1:0]  w_gp;   // group propagate
    logic [GROUPS-1:0]  w_gg;   // group generate
    logic [GROUPS:0]    w_gc;   // carry into each group, [GROUPS] = cout

    assign w_p = a ^ b;
    assign w_g = a & b;

    // First level: per-group lookahead of the internal bit carries and the
    // group generate/propagate terms.
    for (genvar j = 0; j < GROUPS; j++) begin : g_group
        localparam int B = 4 * j;

        assign w_bc[B]     = w_gc[j];
        assign w_bc[B + 1] = w_g[B]
                           | (w_p[B] & w_gc[j]);
        assign w_bc[B + 2] = w_g[B + 1]
                           | (w_p[B + 1] & w_g[B])
                           | (w_p[B + 1] & w_p[B] & w_gc[j]);
        assign w_bc[B + 3] = w_g[B + 2]
                           | (w_p[B + 2] & w_g[B + 1])
                           | (w_p[B + 2] & w_p[B + 1] & w_g[B])
                           | (w_p[B + 2] & w_p[B + 1] & w_p[B] & w_gc[j]);

        assign w_gp[j] = &w_p[B +: 4];
        assign w_gg[j] = w_g[B + 3]
                       | (w_p[B + 3] & w_g[B + 2])
                       | (w_p[B + 3] & w_p[B + 2] & w_g[B + 1])
                       | (w_p[B + 3] & w_p[B + 2] & w_p[B + 1] & w_g[B]);
    end

    // Second level: group carries expanded from cin so the slice depth is
    // two lookahead levels regardless of data.
    assign w_gc[0] = cin;
    assign w_gc[1] = w_gg[0]
                   | (w_gp[0] & cin);
    assign w_gc[2] = w_gg[1]
                   | (w_gp[1] & w_gg[0])
                   | (w_gp[1] & w_gp[0] & cin);
    assign w_gc[3] = w_gg[2]
                   | (w_gp[2] & w_gg[1])
                   | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
    assign w_gc[4] = w_gg[3]
                   | (w_gp[3] & w_gg[2])
                   | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

    assign sum     = w_p ^ w_bc;
    assign cout    = w_gc[GROUPS];
    assign msb_cin = w_bc[SLICE_W-1];

endmodule : add16_slice
`default_nettype wire

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_seq
//  Description : Multi-cycle wide adder/subtractor. Operands of WORDS x 16
//                bits are accepted over a valid/ready handshake and summed
//                one word per cycle on a single add16_slice, carrying
//                between words through a register. The result is returned
//                over a second valid/ready handshake. Slice inputs are held
//                at zero outside RUN to avoid needless toggling.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                in_valid/in_ready          - operand handshake
//                in_a, in_b, in_cin, in_sub - operands and operation
//                out_valid/out_ready        - result handshake
//                out_sum, out_cout, out_ovf - result, carry, signed overflow
//                busy                       - high in RUN or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module wide_add_seq
    import alu_pkg::*;
#(
    parameter int WORDS = 4
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*WORDS-1:0]   in_a,
    input  logic [SLICE_W*WORDS-1:0]   in_b,
    input  logic                       in_cin,
    input  logic                       in_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   out_sum,
    output logic                       out_cout,
    output logic                       out_ovf,
    output logic                       busy
);

    localparam int                DATA_W   = SLICE_W * WORDS;
    localparam int                IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    if (!words_legal(WORDS)) begin : g_words_check
        $error("wide_add_seq: WORDS must lie in 2..16");
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_b_inv;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_run;
    logic [SLICE_W-1:0] w_sl_a;
    logic [SLICE_W-1:0] w_sl_b;
    logic               w_sl_cin;
    logic [SLICE_W-1:0] w_sl_sum;
    logic               w_sl_cout;
    logic               w_sl_msb_cin;

    assign w_run = (r_state == ST_RUN);

    // Operand isolation: the slice sees all-zero inputs unless computing.
    // Subtraction is A + ~B + 1, the +1 coming from the preset carry.
    assign w_sl_a   = w_run ? r_a[r_idx*SLICE_W +: SLICE_W] : '0;
    assign w_sl_b   = w_run ? (r_b[r_idx*SLICE_W +: SLICE_W] ^ {SLICE_W{r_b_inv}})
                            : '0;
    assign w_sl_cin = w_run & r_carry;

    add16_slice u_slice (
        .a       (w_sl_a),
        .b       (w_sl_b),
        .cin     (w_sl_cin),
        .sum     (w_sl_sum),
        .cout    (w_sl_cout),
        .msb_cin (w_sl_msb_cin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_b_inv <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_b_inv <= in_sub;
                        r_carry <= in_sub | in_cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[r_idx*SLICE_W +: SLICE_W] <= w_sl_sum;
                    r_carry                         <= w_sl_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_sl_cout;
                        // Carry into the sign bit differing from carry out
                        // is exactly "same-sign operands, different-sign sum".
                        r_ovf   <= w_sl_msb_cin ^ w_sl_cout;
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state register only.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

endmodule : wide_add_seq
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_add_seq
//  Description : Self-checking bench for wide_add_seq with WORDS=4. Directed
//                vector table, randomized operands against a whole-width
//                arithmetic reference, plus backpressure and mid-RUN reset
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_cin = 1'b0;
    logic          in_sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          busy;

    int checks = 0;
    int errors = 0;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic chk(input string nm, input string what,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
        end
    endtask

    // Reference: the whole operation as one wide integer sum.
    // Returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] bp;
        logic [W:0]   full;
        logic         ovf;
        bp   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + (W+1)'(sub ? 1'b1 : cin);
        ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full};
    endfunction

    // Full transaction. Called #1 after a rising edge with the DUT in IDLE.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        chk(nm, "in_ready_before", W'(in_ready), W'(1));
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk(nm, "busy_after_accept", W'(busy), W'(1));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk(nm, "latency", W'(n), W'(WORDS));
        chk(nm, "sum", out_sum, es);
        chk(nm, "cout", W'(out_cout), W'(ec));
        chk(nm, "ovf", W'(out_ovf), W'(eo));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk(nm, "out_valid_after_hs", W'(out_valid), W'(0));
        chk(nm, "in_ready_after_hs", W'(in_ready), W'(1));
        chk(nm, "sum_held_idle", out_sum, es);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{"full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                   64'h0, 1'b1, 1'b0};
        tbl[1] = '{"word_boundary", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
                   64'h0000_0000_0001_0000, 1'b0, 1'b0};
        tbl[2] = '{"cin_only", 64'h0, 64'h0, 1'b1, 1'b0,
                   64'h1, 1'b0, 1'b0};
        tbl[3] = '{"sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[4] = '{"sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        tbl[5] = '{"add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset", "in_ready", W'(in_ready), W'(1));
        chk("reset", "out_valid", W'(out_valid), W'(0));
        chk("reset", "busy", W'(busy), W'(0));
        chk("reset", "out_sum", out_sum, '0);
        chk("reset", "out_cout", W'(out_cout), W'(0));
        chk("reset", "out_ovf", W'(out_ovf), W'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 6; i++)
            run_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                   tbl[i].sum, tbl[i].cout, tbl[i].ovf);

        // Randomized operands against the reference
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            logic         cin, sub;
            logic [W+1:0] r;
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            if (i % 8 == 3) b = ~a;            // long carry chains
            if (i % 8 == 5) b = a;             // equal operands
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            r   = model(a, b, cin, sub);
            run_op($sformatf("rand%0d", i), a, b, cin, sub, r[W-1:0], r[W], r[W+1]);
        end

        // Backpressure: result held, in_valid during DONE ignored
        begin
            logic [W+1:0] r;
            int n;
            r = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
            in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h0FED_CBA9_8765_4321;
            in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1 n++;
            end
            chk("bp", "latency", W'(n), W'(WORDS));
            for (int c = 0; c < 5; c++) begin
                if (c == 1) begin
                    in_a = 64'hAAAA_AAAA_AAAA_AAAA; in_b = 64'h5555_5555_5555_5555;
                    in_sub = 1'b1; in_valid = 1'b1;
                end
                if (c == 3) in_valid = 1'b0;
                @(posedge clk);
                #1;
                chk($sformatf("bp_hold%0d", c), "out_valid", W'(out_valid), W'(1));
                chk($sformatf("bp_hold%0d", c), "out_sum", out_sum, r[W-1:0]);
                chk($sformatf("bp_hold%0d", c), "in_ready", W'(in_ready), W'(0));
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            chk("bp_release", "in_ready", W'(in_ready), W'(1));
            chk("bp_release", "busy", W'(busy), W'(0));
            @(posedge clk);
            #1;
            chk("bp_no_phantom", "busy", W'(busy), W'(0));
            chk("bp_no_phantom", "out_sum", out_sum, r[W-1:0]);
            r = model(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b1);
            run_op("bp_next", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b1,
                   r[W-1:0], r[W], r[W+1]);
        end

        // Reset mid-RUN
        in_a = 64'h0123_4567_89AB_CDEF; in_b = 64'h1111_2222_3333_4444;
        in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid", "out_valid", W'(out_valid), W'(0));
        chk("rst_mid", "busy", W'(busy), W'(0));
        chk("rst_mid", "in_ready", W'(in_ready), W'(1));
        chk("rst_mid", "out_sum", out_sum, '0);
        chk("rst_mid", "out_cout", W'(out_cout), W'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("after_rst", 64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wide_add_seq
`default_nettype wire

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle wide adder/subtractor sequencer for the ALU16 datapath. It accepts WORDS×16-bit operands over a valid/ready handshake and reuses a single 16-bit carry-lookahead slice over WORDS cycles, carrying between words through a register. The result is returned over a second valid/ready handshake. Trading area for latency this way keeps wide arithmetic on one adder slice. The slice's inputs are isolated (held at zero) whenever the block is not computing, for dynamic-power savings.

## Interface
- WORDS, 4, number of 16-bit words per operand; legal range 2..16
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept; high only in IDLE
- in_a  in  16*WORDS  operand A
- in_b  in  16*WORDS  operand B
- in_cin  in  1  carry-in; used only when in_sub=0
- in_sub  in  1  1 = A − B, 0 = A + B + cin
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  16*WORDS  result
- out_cout  out  1  carry out of MSB; for subtract, 1 = no borrow
- out_ovf  out  1  two's-complement signed overflow
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid & in_ready, capture in_a and in_b into registers.
  - Set the operation register: b_inv = in_sub.
  - Set carry register: carry = in_sub ? 1 : in_cin.
  - Set word index idx=0, clear the result register, go to RUN.
- **RUN**
  - Each cycle the slice computes a[idx] + (b[idx] ^ {16{b_inv}}) + carry.
  - Write the 16-bit sum into result word idx; carry ← slice cout; idx ← idx+1.
  - When idx == WORDS−1, latch the final values and go to DONE:
    - out_cout = slice cout.
    - out_ovf = (a_msb == b'_msb) & (sum_msb != a_msb), where b' is the inverted-if-subtract operand.
- **DONE**
  - out_valid=1; out_sum, out_cout and out_ovf held stable.
  - On out_ready go to IDLE.
- Holding behaviour:
  - out_sum, out_cout and out_ovf keep their last values in IDLE until the next accept clears them.
  - Operand registers load only on accept.
- Operand isolation: slice inputs and carry-in are forced to 0 outside RUN.
- in_valid in RUN or DONE is ignored; there is no queueing.
- Reset, asserted at any time, including mid-RUN:
  - State goes to IDLE; idx, carry, operand and result registers, out_cout and out_ovf all go to 0.
  - out_valid=0 and busy=0; any in-flight result is discarded.
  - in_ready=1 immediately while in IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0.
- Latency: with the accept at edge k, out_valid goes high after edge k+WORDS (WORDS RUN cycles).
- out_valid is a registered state decode; in_ready is a combinational decode of state only, with no combinational path from in_valid or out_ready.
- Output handshake:
  - Completes on the edge where out_valid & out_ready.
  - in_ready rises in the following cycle.
- Minimum initiation interval is WORDS+2 cycles (accept, WORDS RUN cycles, DONE, IDLE), achieved with out_ready held high.
- Critical path: one 16-bit lookahead slice plus the carry register. No inter-word ripple occurs within a single cycle.

## Structure
- Shared package alu_pkg holds:
  - state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - SLICE_W=16;
  - the WORDS legality check.
- Sub-module add16_slice: a 16-bit adder built from four 4-bit lookahead groups with a second-level group carry. Ports are a, b, cin, sum, cout, and msb_cin for overflow debug. It is instantiated once.
- Word index width is $clog2(WORDS).

## Test plan
WORDS=4 throughout.
- **Full carry ripple:** a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 → sum=0, cout=1, ovf=0; out_valid exactly 4 cycles after the accept edge.
- **Word-boundary carry:** a=0x0000_0000_0000_FFFF, b=1 → sum=0x0000_0000_0001_0000, cout=0. Then cin=1 with a=b=0 → sum=1.
- **Subtract:**
  - a=5, b=7, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - a=0x8000_0000_0000_0000, b=1, sub=1 → sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
- **Signed add overflow:** a=0x7FFF_FFFF_FFFF_FFFF, b=1 → sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- **Backpressure:** out_ready=0 for 5 cycles, with in_valid pulsed during DONE.
  - out_valid and out_sum are held; in_ready=0; the new operands are not captured.
  - out_ready=1 → in_ready=1 on the next cycle, then the new request is accepted.
- **Reset mid-RUN:** assert rst_n=0 two cycles after accept.
  - Immediately: out_valid=0, busy=0, in_ready=1, out_sum=0.
  - After release, a=b=1 → sum=2 with the normal 4-cycle latency.
